vram_scanout: RTL
=================

VRAM_SCANOUT -- requirements
Module: vram_scanout

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, SHALL set the width of the VRAM read address.
REQ-002 Parameters H_ACTIVE=256, H_TOTAL=320, V_ACTIVE=224, V_TOTAL=262 SHALL set the timing in pixels and lines.
REQ-003 Parameters HS_START=272, HS_END=304, VS_START=236, VS_END=240 SHALL set the sync windows, each start-inclusive and end-exclusive.
REQ-004 Parameter MID_LINE, default 96, SHALL set the line of the mid-screen interrupt.
REQ-005 Port clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port pix_en, input, 1 bit: pixel-step enable; counters and outputs SHALL advance only in cycles where it is high.
REQ-008 Port vram_addr, output, ADDR_WIDTH bits: combinational read address to the RAM read-only port.
REQ-009 Port vram_data, input, 8 bits: combinational read data returned for vram_addr in the same cycle.
REQ-010 Ports pixel, de, hsync, vsync, outputs, 1 bit each: registered video outputs, all active-high.
REQ-011 Ports irq_mid and irq_vblank, outputs, 1 bit each: single-clk interrupt strobes.

Function
REQ-012 The counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) SHALL change only on cycles where pix_en is high.
REQ-013 On a pix_en step, h SHALL wrap from H_TOTAL-1 to 0 and increment v at the same step.
REQ-014 On a pix_en step where h=H_TOTAL-1 and v=V_TOTAL-1, the counters SHALL move to (0,0).
REQ-015 Active region: h<H_ACTIVE and v<V_ACTIVE.
REQ-016 vram_addr SHALL equal v*32 + h[7:3] while the counters are in the active region, and 0 otherwise.
REQ-017 On a pix_en step in the active region with h[2:0]=0, pixel SHALL be loaded with vram_data[0] and the shift register with vram_data>>1 (LSB = leftmost pixel).
REQ-018 On a pix_en step in the active region with h[2:0]≠0, pixel SHALL be loaded with shreg[0] and shreg shifted right by one.
REQ-019 On a pix_en step outside the active region, pixel SHALL be loaded with 0 and shreg left unchanged.
REQ-020 On each pix_en step, de, hsync and vsync SHALL register the active, sync-window (h) and sync-window (v) conditions of the pre-step counters, giving the same one-step latency as pixel.
REQ-021 All registered outputs SHALL hold their values in cycles where pix_en is low.
REQ-022 irq_mid SHALL be high for exactly one clk, in the cycle after the pix_en step that moves the counters to (0, MID_LINE).
REQ-023 irq_vblank SHALL be high for exactly one clk, in the cycle after the pix_en step that moves the counters to (0, V_ACTIVE).
REQ-024 Neither irq strobe SHALL re-fire while the counters sit at the trigger position with pix_en low.

Reset
REQ-025 When rst is high at a clk edge, h, v, shreg, pixel, de, hsync, vsync, irq_mid and irq_vblank SHALL all become 0, with reset taking priority over pix_en.
REQ-026 After rst is released mid-frame, scanning SHALL restart at (0,0), and the first pixel SHALL come from address 0 on the next pix_en step.

Structure
REQ-027 Package video_pkg SHALL hold the default timing constants (H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL, sync bounds, MID_LINE) and the bytes-per-line constant 32.
REQ-028 Sub-module video_timing SHALL own the h/v counters and the active/sync/irq decode, and vram_scanout SHALL own address generation and the shift register.

Verification
REQ-029 RAM model with byte 0x01 at address 0 and all other bytes 0, pix_en held high -> pixel=1 only on the first active step of line 0; pixel pattern at steps 1-8 = 1,0,0,0,0,0,0,0.
REQ-030 Byte 0xA5 at address 0x0021 -> line 1, pixels 8-15 = 1,0,1,0,0,1,0,1, and vram_addr=0x0021 while h=8..15, v=1.
REQ-031 Full frame with pix_en high -> exactly 320*262 steps per frame; irq_mid once and irq_vblank once per frame, separated by 128*320 steps; de high for 256*224 steps.
REQ-032 pix_en toggling 1-of-4 cycles -> identical pixel sequence to REQ-029 at the reduced rate; outputs stable between steps; irq pulses still 1 clk wide.
REQ-033 rst asserted at (h=100, v=50) for one clk -> all outputs 0 on the next cycle; next frame's irq_mid arrives 96*320 steps after release.
REQ-034 Counters at (H_TOTAL-1, V_TOTAL-1) on a pix_en step -> (0,0), vram_addr=0, no irq strobe.

Source files
------------

// File: rtl/video_pkg.sv
// Default raster timing for the bitmap scanout: 256x224 active inside a 320x262 frame.
// Shared by the timing generator and the address/pixel path.
package video_pkg;

  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_H_TOTAL  = 320;
  localparam int DEF_V_ACTIVE = 224;
  localparam int DEF_V_TOTAL  = 262;
  localparam int DEF_HS_START = 272;
  localparam int DEF_HS_END   = 304;
  localparam int DEF_VS_START = 236;
  localparam int DEF_VS_END   = 240;
  localparam int DEF_MID_LINE = 96;

  localparam int BYTES_PER_LINE = 32;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

endpackage

// File: rtl/video_timing.sv
// Raster h/v counters with active/sync decode and line-entry interrupt strobes.
// de/hsync/vsync lag the counters by one pix_en step; irqs are single-clk pulses; holds when pix_en low.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END   = DEF_HS_END,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END   = DEF_VS_END,
  parameter int MID_LINE = DEF_MID_LINE,
  parameter int HW       = $clog2(H_TOTAL),
  parameter int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          active,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          irq_mid,
  output logic          irq_vblank
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_S   = HW'(HS_START);
  localparam logic [HW-1:0] HS_E   = HW'(HS_END);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_S   = VW'(VS_START);
  localparam logic [VW-1:0] VS_E   = VW'(VS_END);
  localparam logic [VW-1:0] V_MID  = VW'(MID_LINE);

  logic          line_end;
  logic [VW-1:0] v_next;
  sync_t         sync_d;
  sync_t         sync_q;

  always_comb begin
    line_end = (h == H_LAST);
    v_next   = (v == V_LAST) ? '0 : v + 1'b1;
    active   = (h < H_ACT) && (v < V_ACT);
    sync_d   = '{de:    active,
                 hsync: (h >= HS_S) && (h < HS_E),
                 vsync: (v >= VS_S) && (v < VS_E)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        h <= '0;
        v <= v_next;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Strobes fire only on the step that enters the trigger line, so a stalled pix_en cannot re-arm them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      irq_mid    <= 1'b0;
      irq_vblank <= 1'b0;
    end else begin
      irq_mid    <= pix_en && line_end && (v_next == V_MID);
      irq_vblank <= pix_en && line_end && (v_next == V_ACT);
      if (pix_en) begin
        sync_q <= sync_d;
      end
    end
  end

  assign de    = sync_q.de;
  assign hsync = sync_q.hsync;
  assign vsync = sync_q.vsync;

endmodule

// File: rtl/vram_scanout.sv
// 1bpp bitmap scanout: combinational VRAM address from the raster position, byte shifted out LSB first.
// Pixel and sync outputs lag the counters by one pix_en step; everything holds while pix_en is low.
module vram_scanout
  import video_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_TOTAL    = DEF_H_TOTAL,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_TOTAL    = DEF_V_TOTAL,
  parameter int HS_START   = DEF_HS_START,
  parameter int HS_END     = DEF_HS_END,
  parameter int VS_START   = DEF_VS_START,
  parameter int VS_END     = DEF_VS_END,
  parameter int MID_LINE   = DEF_MID_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_en,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  input  logic [7:0]            vram_data,
  output logic                  pixel,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  irq_mid,
  output logic                  irq_vblank
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          active;
  logic [6:0]    shreg;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .HS_START (HS_START),
    .HS_END   (HS_END),
    .VS_START (VS_START),
    .VS_END   (VS_END),
    .MID_LINE (MID_LINE),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .h          (h),
    .v          (v),
    .active     (active),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .irq_mid    (irq_mid),
    .irq_vblank (irq_vblank)
  );

  always_comb begin
    vram_addr = '0;
    if (active) begin
      vram_addr = ADDR_WIDTH'(v) * ADDR_WIDTH'(BYTES_PER_LINE) + ADDR_WIDTH'(h >> 3);
    end
  end

  // Bit 0 goes straight to the pixel on the byte fetch; the upper seven wait in shreg.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel <= 1'b0;
      shreg <= '0;
    end else if (pix_en) begin
      if (!active) begin
        pixel <= 1'b0;
      end else if (h[2:0] == 3'd0) begin
        pixel <= vram_data[0];
        shreg <= vram_data[7:1];
      end else begin
        pixel <= shreg[0];
        shreg <= {1'b0, shreg[6:1]};
      end
    end
  end

endmodule
